// File: rtl/key_onehot_scanner.sv
// key_onehot_scanner: turns N raw, bouncy key lines into one-hot press events
// for the 8-to-3 encoder. Each line is synchronised, debounced and
// rising-edge detected. Presses are queued in a pending register and handed
// out one at a time, lowest index first, over a valid/ready handshake.
module key_onehot_scanner #(
  parameter int N               = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] key_in,
  input  logic         y_ready,
  output logic [N-1:0] Y,
  output logic         y_valid,
  output logic [N-1:0] pending,
  output logic         ovr
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Isolate the lowest set bit; this is the priority pick of the queue.
  function automatic logic [N-1:0] lowest_bit(input logic [N-1:0] v);
    return v & (~v + N'(1));
  endfunction

  logic [N-1:0]  s1_p0;
  logic [N-1:0]  s2_p1;
  logic [N-1:0]  stable_p2;
  logic [CW-1:0] cnt_p2     [N];
  logic [N-1:0]  stable_nxt;
  logic [CW-1:0] cnt_nxt    [N];
  logic [N-1:0]  rise;
  logic [N-1:0]  pick;
  logic [N-1:0]  take;
  logic          load;
  logic          drain;

  // Stage 0/1: two-flop synchroniser per key line.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_p0 <= '0;
      s2_p1 <= '0;
    end else begin
      s1_p0 <= key_in;
      s2_p1 <= s1_p0;
    end
  end

  // Debounce next state: a changed level must persist DEBOUNCE_CYCLES cycles;
  // any return to the stable level restarts the count.
  always_comb begin
    stable_nxt = stable_p2;
    for (int i = 0; i < N; i++) begin
      cnt_nxt[i] = '0;
      if (s2_p1[i] != stable_p2[i]) begin
        if (cnt_p2[i] == CNT_MAX) begin
          stable_nxt[i] = s2_p1[i];
        end else begin
          cnt_nxt[i] = cnt_p2[i] + CW'(1);
        end
      end
    end
  end

  // Stage 2: debounced level and per-line persistence counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_p2 <= '0;
      for (int i = 0; i < N; i++) cnt_p2[i] <= '0;
    end else begin
      stable_p2 <= stable_nxt;
      for (int i = 0; i < N; i++) cnt_p2[i] <= cnt_nxt[i];
    end
  end

  // Rise is taken from the flip itself so pending sets on the same edge as
  // stable; the output loader picks the lowest pending bit when it is free.
  always_comb begin
    rise  = stable_nxt & ~stable_p2;
    pick  = lowest_bit(pending);
    load  = (~y_valid | y_ready) & (pending != '0);
    take  = load ? pick : '0;
    drain = y_valid & y_ready & (pending == '0);
  end

  // Stage 3: pending queue and sticky overrun (set wins over take).
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      ovr     <= 1'b0;
    end else begin
      pending <= (pending & ~take) | rise;
      if ((rise & pending & ~take) != '0) ovr <= 1'b1;
    end
  end

  // Stage 4: registered one-hot output; held while stalled, cleared on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      Y       <= '0;
      y_valid <= 1'b0;
    end else if (load) begin
      Y       <= pick;
      y_valid <= 1'b1;
    end else if (drain) begin
      Y       <= '0;
      y_valid <= 1'b0;
    end
  end

endmodule

// File: doc/key_onehot_scanner.md
Name: key_onehot_scanner

Overview:
- Upstream front end for the 8-to-3 encoder: turns 8 raw, asynchronous, bouncy key/switch lines into clean one-hot codes on Y[7:0], one key per transfer.
- Synchronises, debounces and rising-edge-detects each line, then queues press events in a pending register.
- Presents them to the encoder one at a time, lowest index first, with a valid/ready handshake.
- Guarantees Y is all-zero or exactly one-hot, the input contract of the encoder.

Parameters:
- N, 8, number of key lines; fixed at 8 for the encoder pairing, must be ≥2.
- DEBOUNCE_CYCLES, 4, consecutive synchronised cycles a changed level must persist before it is accepted; must be ≥1. Counter width is $clog2(DEBOUNCE_CYCLES+1).

Ports:
- clk, input, 1, single system clock; all state updates on its rising edge.
- rst, input, 1, synchronous reset, active-high.
- key_in, input, N, raw asynchronous key levels; 1 = pressed.
- y_ready, input, 1, downstream accepts the current Y this cycle.
- Y, output, N, registered one-hot key code to the encoder; all-zero when y_valid = 0.
- y_valid, output, 1, Y holds a valid press event.
- pending, output, N, queued press events not yet presented; observation only.
- ovr, output, 1, sticky overrun flag.

Behaviour:
- Reset: all registers are cleared on a clk edge with rst = 1. This covers sync flops, debounced state, counters, pending, Y, y_valid and ovr. rst overrides every other event, including mid-debounce and mid-handshake. After reset, Y = 0, y_valid = 0, pending = 0, ovr = 0.
- Synchroniser: each bit uses a 2-flop chain, key_in → s1 → s2. Only s2 is used downstream.
- Debounce, per bit, with stable[i] reset to 0:
  - If s2[i] == stable[i], cnt[i] ← 0.
  - Else, if cnt[i] == DEBOUNCE_CYCLES-1, stable[i] ← s2[i] and cnt[i] ← 0.
  - Else, cnt[i] ← cnt[i] + 1.
  - Any glitch back to the stable level restarts the count.
- Edge detect: rise[i] = 1 on the cycle stable[i] flips 0→1. Releases (1→0) produce no event.
- Pending update, per bit, on each edge:
  - pending[i] ← (pending[i] & ~take[i]) | rise[i].
  - take is the one-hot bit loaded into Y this cycle.
  - If rise[i] and take[i] coincide, set wins and the bit stays pending.
- Overrun: if rise[i] occurs while pending[i] = 1 and take[i] = 0, ovr ← 1. The event is merged, not counted. ovr clears only on rst.
- Output stage:
  - load = (~y_valid | y_ready) & (pending != 0).
  - take = lowest set bit of pending.
  - On load: Y ← take, y_valid ← 1.
  - On (y_valid & y_ready & pending == 0): Y ← 0, y_valid ← 0.
  - Otherwise Y and y_valid hold; Y is stable while y_valid = 1 and y_ready = 0.
- Throughput: back-to-back transfers, one per cycle, while y_ready = 1 and pending is non-zero.
- Latency:
  - Edge 0 is the first clk edge at which key_in[i] = 1 is sampled, held clean.
  - s2 goes high after edge 1.
  - stable and pending go high after edge DEBOUNCE_CYCLES+1.
  - Y/y_valid go high after edge DEBOUNCE_CYCLES+2, if the output is idle. This is 6 cycles for the default.
- Priority: when several bits are pending, the lowest index is served first. Higher bits wait without starvation protection.
- Y is never multi-hot. Y != 0 if and only if y_valid = 1.

Test Plan:
- Reset: drive rst = 1 for 2 cycles with key_in = 8'hFF → Y = 0, y_valid = 0, pending = 0, ovr = 0 throughout. Release rst with key_in held → first press reported 6 cycles later.
- Clean press: key_in = 8'h04 held, y_ready = 1, default params → y_valid rises exactly 6 edges after first sampling with Y = 8'h04. It deasserts after 1 cycle. Releasing the key gives no further event.
- Bounce reject: on bit 5, key_in toggles high 3 cycles / low 1 cycle, repeated 4 times, then low → y_valid stays 0, pending stays 0.
- Priority and backpressure: key_in = 8'h81 simultaneously, y_ready = 0 → Y = 8'h01 held and pending = 8'h80 for 5 cycles. Raise y_ready → next cycle Y = 8'h80, then Y = 0, y_valid = 0.
- Overrun: y_ready = 0, press bit 3 until delivered, release, then debounce a second press of bit 3 while bit 3 is still pending behind a held Y = 8'h01 → ovr = 1. Only one Y = 8'h08 transfer occurs after y_ready = 1.
- Reset mid-operation: assert rst while y_valid = 1 with Y = 8'h02 and pending = 8'h10 → next edge Y = 0, y_valid = 0, pending = 0. No stale event appears after rst is released with key_in = 0.
